// File: rtl/ds_pkg.sv
// Shared definitions for the down-sample processor and its result streamer.
// Latency: none (types and constants only).
// Backpressure: n/a.
// Contents: streamer state encoding, default bus widths, default result
// region (base/length) shared with the processor top.
package ds_pkg;

  localparam int DS_DATA_W = 8;
  localparam int DS_ADDR_W = 16;

  // Default result region written by the processor and read back out.
  localparam logic [DS_ADDR_W-1:0] RESULT_BASE_ADDR = 16'h0000;
  localparam int                   RESULT_LENGTH    = 16384;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LATCH,
    SEND,
    CSUM,
    DONE
  } state_t;

  // States in which the streamer owns the data-memory address bus.
  function automatic logic owns_bus(input state_t s);
    return (s == ADDR) || (s == LATCH) || (s == SEND) || (s == CSUM);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for a valid/ready byte stream.
// Latency: 1 cycle from load to out_valid/out_data.
// Backpressure: out_data/out_valid held stable until out_ready; load has priority.
// Ports: clk, rst_n (async active-low); load/load_data capture a new byte and
// raise out_valid; out_ready completes the transfer and drops out_valid.
module stream_out_reg
  import ds_pkg::*;
#(
  parameter int DATA_W = DS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      // A load can coincide with the accept of the previous byte (checksum
      // byte follows the last data byte back to back), so it wins.
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/result_streamer.sv
// Streams the down-sampled result region out of data memory once the
// processor reports finished. Latency: mem_sel/mem_addr 1 cycle after finished
// is sampled, first out_valid 3 cycles after; 3 cycles per byte minimum.
// Backpressure: byte held on out_data/out_valid until out_ready; no read-ahead.
// Ports: clk, rst_n (async active-low); finished (level) from the processor;
// mem_sel/mem_addr/mem_rdata = data-memory read port (sync RAM, 1-cycle read);
// out_data/out_valid/out_ready = byte stream; busy while streaming; done held
// until finished drops.
// Build option: RESULT_STREAMER_CHECKSUM_EN appends an 8-bit mod-256 sum of
// all data bytes as one extra stream byte.
module result_streamer
  import ds_pkg::*;
#(
  parameter int                ADDR_W    = DS_ADDR_W,
  parameter int                DATA_W    = DS_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RESULT_BASE_ADDR),
  parameter int                LENGTH    = RESULT_LENGTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              finished,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // One extra counter bit so LENGTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(LENGTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   counter_q, counter_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_sel_q, mem_sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              xfer;

`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign xfer = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    mem_addr_d = mem_addr_q;
    load       = 1'b0;
    load_data  = mem_rdata;
`ifdef RESULT_STREAMER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (finished) begin
          state_d    = ADDR;
          counter_d  = '0;
          mem_addr_d = BASE_ADDR;
`ifdef RESULT_STREAMER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end

      // Address is on the bus this cycle; the RAM returns data next cycle.
      ADDR: state_d = LATCH;

      LATCH: begin
        load    = 1'b1;
        state_d = SEND;
      end

      SEND: begin
        if (xfer) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
          sum_d = sum_q + out_data;
`endif
          if (counter_q == LAST_IDX) begin
`ifdef RESULT_STREAMER_CHECKSUM_EN
            // Sum including the byte accepted on this same edge.
            load      = 1'b1;
            load_data = sum_q + out_data;
            state_d   = CSUM;
`else
            state_d   = DONE;
`endif
          end else begin
            counter_d  = counter_q + CNT_ONE;
            mem_addr_d = mem_addr_q + ADR_ONE;  // wraps modulo 2**ADDR_W
            state_d    = ADDR;
          end
        end
      end

`ifdef RESULT_STREAMER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_d = DONE;
      end
`endif

      // finished must be seen low before another stream can start.
      DONE: begin
        if (!finished) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Outputs registered from the next state so the address mux select
    // never glitches with finished.
    mem_sel_d = owns_bus(state_d);
    busy_d    = owns_bus(state_d);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      mem_addr_q <= BASE_ADDR;
      mem_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESULT_STREAMER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      mem_addr_q <= mem_addr_d;
      mem_sel_q  <= mem_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef RESULT_STREAMER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  stream_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  assign mem_sel  = mem_sel_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: two instances (plain region and wrapping
// region) each backed by a behavioural synchronous RAM; accepted bytes are
// collected at the handshake and compared with the expected region contents.
module tb_result_streamer;

  localparam logic [15:0] BASE_A = 16'h0100;
  localparam logic [15:0] BASE_W = 16'hFFFE;
  localparam int          LEN    = 4;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  localparam int          CS     = 1;
`else
  localparam int          CS     = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fin_a, rdy_a, sel_a, val_a, busy_a, done_a;
  logic        fin_w, rdy_w, sel_w, val_w, busy_w, done_w;
  logic [15:0] addr_a, addr_w;
  logic [7:0]  rdat_a, rdat_w, dat_a, dat_w;

  logic [7:0]  ram_a [0:65535];
  logic [7:0]  ram_w [0:65535];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [7:0]  acc_dat_a[$], acc_dat_w[$];
  logic [15:0] acc_adr_a[$], acc_adr_w[$];
  int          acc_cyc_a[$], acc_cyc_w[$];
  logic [7:0]  exp_dat[$];
  logic [15:0] exp_adr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rdat_a <= ram_a[addr_a];
  always @(posedge clk) rdat_w <= ram_w[addr_w];

  result_streamer #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(BASE_A), .LENGTH(LEN)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .finished(fin_a), .mem_sel(sel_a), .mem_addr(addr_a),
    .mem_rdata(rdat_a), .out_data(dat_a), .out_valid(val_a), .out_ready(rdy_a),
    .busy(busy_a), .done(done_a)
  );

  result_streamer #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(BASE_W), .LENGTH(LEN)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .finished(fin_w), .mem_sel(sel_w), .mem_addr(addr_w),
    .mem_rdata(rdat_w), .out_data(dat_w), .out_valid(val_w), .out_ready(rdy_w),
    .busy(busy_w), .done(done_w)
  );

  // Handshake monitor: inputs settle 1 time unit after posedge, so a
  // valid&ready seen at the negedge is the transfer of the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (val_a && rdy_a) begin
        acc_dat_a.push_back(dat_a); acc_adr_a.push_back(addr_a); acc_cyc_a.push_back(cyc);
      end
      if (val_w && rdy_w) begin
        acc_dat_w.push_back(dat_w); acc_adr_w.push_back(addr_w); acc_cyc_w.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int acc_size(input bit w);
    return w ? acc_dat_w.size() : acc_dat_a.size();
  endfunction

  task automatic clear_acc(input bit w);
    if (w) begin acc_dat_w.delete(); acc_adr_w.delete(); acc_cyc_w.delete(); end
    else   begin acc_dat_a.delete(); acc_adr_a.delete(); acc_cyc_a.delete(); end
  endtask

  task automatic set_fin(input bit w, input logic v);
    if (w) fin_w = v; else fin_a = v;
  endtask

  task automatic set_rdy(input bit w, input logic v);
    if (w) rdy_w = v; else rdy_a = v;
  endtask

  // Reference: the region is LEN consecutive bytes from base, addresses
  // wrapping at 64K, optionally followed by their sum modulo 256.
  task automatic build_exp(input bit w);
    logic [15:0] base, a;
    logic [7:0]  b;
    int          sum;
    base = w ? BASE_W : BASE_A;
    sum  = 0;
    exp_dat.delete();
    exp_adr.delete();
    for (int i = 0; i < LEN; i++) begin
      a = 16'((int'(base) + i) % 65536);
      b = w ? ram_w[a] : ram_a[a];
      exp_dat.push_back(b);
      exp_adr.push_back(a);
      sum = sum + int'(b);
    end
    if (CS != 0) exp_dat.push_back(8'(sum % 256));
  endtask

  task automatic compare(input bit w, input string tag);
    int n;
    build_exp(w);
    n = acc_size(w);
    chk({tag, "_count"}, n, exp_dat.size());
    for (int i = 0; i < n && i < exp_dat.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), w ? acc_dat_w[i] : acc_dat_a[i], exp_dat[i]);
      if (i < LEN)
        chk($sformatf("%s_addr%0d", tag, i), w ? acc_adr_w[i] : acc_adr_a[i], exp_adr[i]);
    end
  endtask

  // mode 0: ready high; mode 1: random ready; mode 2: ready high except a
  // 5-cycle stall while the second byte is presented.
  task automatic run_stream(input bit w, input int mode);
    int          stall;
    int          budget;
    logic [7:0]  bb;
    logic [15:0] a1;
    stall  = 0;
    budget = 0;
    a1     = (w ? BASE_W : BASE_A) + 16'd1;
    bb     = w ? ram_w[a1] : ram_a[a1];
    clear_acc(w);
    step();
    set_fin(w, 1'b1);
    set_rdy(w, 1'b1);
    forever begin
      step();
      if (w ? done_w : done_a) break;
      if (budget >= 300) begin
        chk("stream_timeout", 0, 1);
        break;
      end
      budget++;
      if (mode == 2 && acc_size(w) == 1 && (w ? val_w : val_a) && stall < 5) begin
        set_rdy(w, 1'b0);
        stall++;
        @(negedge clk);
        chk("stall_valid", w ? val_w : val_a, 1);
        chk("stall_data", w ? dat_w : dat_a, bb);
        chk("stall_addr", w ? addr_w : addr_a, a1);
      end else if (mode == 1) begin
        set_rdy(w, 1'($urandom_range(0, 1)));
      end else begin
        set_rdy(w, 1'b1);
      end
    end
    if (mode == 2) chk("stall_cycles", stall, 5);
    chk("end_sel", w ? sel_w : sel_a, 0);
    chk("end_busy", w ? busy_w : busy_a, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    rst_n = 1'b0;
    fin_a = 1'b0; rdy_a = 1'b0;
    fin_w = 1'b0; rdy_w = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ram_a[i] = 8'($urandom);
      ram_w[i] = 8'($urandom);
    end
    ram_a[BASE_A]     = 8'hAA;
    ram_a[BASE_A + 1] = 8'hBB;
    ram_a[BASE_A + 2] = 8'hCC;
    ram_a[BASE_A + 3] = 8'hDD;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", sel_a, 0);
    chk("rst_addr", addr_a, BASE_A);
    chk("rst_data", dat_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_addr_w", addr_w, BASE_W);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // Basic stream with cycle-exact timing; finished is a one-cycle pulse.
    clear_acc(0);
    fin_a = 1'b1;
    rdy_a = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) fin_a = 1'b0;
      @(negedge clk);
      chk($sformatf("basic_sel_c%0d", k), sel_a, (k >= 1 && k <= 12 + CS) ? 1 : 0);
      chk($sformatf("basic_done_c%0d", k), done_a, (k == 13 + CS) ? 1 : 0);
    end
    compare(0, "basic");
    n = acc_cyc_a.size();
    for (int i = 0; i < n && i < LEN + CS; i++)
      chk($sformatf("basic_acc_cycle%0d", i), acc_cyc_a[i] - t0, (i < LEN) ? 3 + 3 * i : 3 * LEN + 1);

    // Backpressure on byte BB
    run_stream(0, 2);
    compare(0, "bp");
    chk("bp_done", done_a, 1);

    // finished held high in DONE: no second stream
    n = acc_size(0);
    repeat (20) step();
    chk("hold_no_stream", acc_size(0), n);
    chk("hold_done", done_a, 1);
    chk("hold_sel", sel_a, 0);

    // Re-arm with one low cycle, random backpressure
    fin_a = 1'b0;
    run_stream(0, 1);
    compare(0, "rearm");

    // Random contents, random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LEN; i++) ram_a[BASE_A + 16'(i)] = 8'($urandom);
      fin_a = 1'b0;
      run_stream(0, 1);
      compare(0, $sformatf("rand%0d", r));
    end

    // Asynchronous reset while CC is in SEND
    ram_a[BASE_A]     = 8'hAA;
    ram_a[BASE_A + 1] = 8'hBB;
    ram_a[BASE_A + 2] = 8'hCC;
    ram_a[BASE_A + 3] = 8'hDD;
    fin_a = 1'b0;
    step();
    clear_acc(0);
    fin_a = 1'b1;
    rdy_a = 1'b1;
    n = 0;
    while (!(acc_size(0) == 2 && val_a) && n < 100) begin
      step();
      n++;
    end
    chk("arst_reached_cc", dat_a, 8'hCC);
    #3;
    rst_n = 1'b0;
    fin_a = 1'b0;
    #1;
    chk("arst_valid", val_a, 0);
    chk("arst_sel", sel_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_addr", addr_a, BASE_A);
    repeat (2) step();
    rst_n = 1'b1;
    chk("arst_dropped", acc_size(0), 2);
    run_stream(0, 0);
    compare(0, "arst_restart");

    // Address wrap at the top of memory
    for (int i = 0; i < LEN; i++) ram_w[16'(int'(BASE_W) + i)] = 8'($urandom);
    run_stream(1, 1);
    compare(1, "wrap");

`ifdef RESULT_STREAMER_CHECKSUM_EN
    ram_w[16'hFFFE] = 8'h01;
    ram_w[16'hFFFF] = 8'h02;
    ram_w[16'h0000] = 8'h03;
    ram_w[16'h0001] = 8'hFF;
    fin_w = 1'b0;
    run_stream(1, 0);
    compare(1, "csum");
    if (acc_dat_w.size() > 4) chk("csum_value", acc_dat_w[4], 8'h05);
    else chk("csum_present", acc_dat_w.size(), 5);
    chk("csum_done", done_w, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
